// File: rtl/instr_decode_queue.sv
// instr_decode_queue
//   Registered decode queue between fetch and register-read/execute.
//
//   Each 32-bit instruction word is decoded on the input side. The decoded
//   fields (groups 0-5) are written into a DEPTH-entry circular queue when
//   the word is accepted.
//
//   The head entry drives out_*. There is no bypass: a word accepted into an
//   empty queue appears at the head one cycle later.
//
//   Optional feature macro: INSTR_DECODE_ILLEGAL_EN
//     When defined, this adds out_illegal, which is stored per entry.
//     Illegal entries never raise causes_stall.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous discard of all entries; wins over push/pop
//   in_valid/in_ready    fetch handshake; in_ready = (count < DEPTH)
//   in_instr, in_pc      instruction word and its PC
//   out_valid/out_ready  execute handshake; out_valid = (count != 0)
//   out_pc .. out_causes_stall   decoded head entry
//   out_illegal          (macro only) head entry is illegal
//   count                occupancy, 0..DEPTH

module instr_decode_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [ADDR_WIDTH-1:0]    in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_WIDTH-1:0]    out_pc,
    output logic [3:0]               out_group,
    output logic [3:0]               out_ra,
    output logic [3:0]               out_rb,
    output logic [3:0]               out_rc,
    output logic [3:0]               out_opcode,
    output logic [DATA_WIDTH-1:0]    out_imm,
    output logic [2:0]               out_ldst_type,
    output logic [3:0]               out_cond_type,
    output logic                     out_causes_stall,
`ifdef INSTR_DECODE_ILLEGAL_EN
    output logic                     out_illegal,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [3:0]            group;
        logic [3:0]            ra;
        logic [3:0]            rb;
        logic [3:0]            rc;
        logic [3:0]            opcode;
        logic [DATA_WIDTH-1:0] imm;
        logic [2:0]            ldst_type;
        logic [3:0]            cond_type;
        logic                  causes_stall;
`ifdef INSTR_DECODE_ILLEGAL_EN
        logic                  illegal;
`endif
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          dec;
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            loaded;
    logic            push;
    logic            pop;

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Input-side decode
    always_comb begin
        logic [3:0] grp;
        logic [3:0] op;
        dec       = '0;
        grp       = in_instr[31:28];
        dec.pc    = in_pc;
        dec.group = grp;
        dec.ra    = in_instr[27:24];
        dec.rb    = in_instr[23:20];
        if (grp == 4'd1 || grp == 4'd2) begin
            op     = in_instr[19:16];
            dec.rc = 4'd0;
        end else begin
            op     = in_instr[3:0];
            dec.rc = in_instr[19:16];
        end
        dec.opcode = op;

        case (grp)
            4'd1: begin
                if (op == 4'd15) begin
                    dec.imm[31:16] = in_instr[15:0];
                end else if (op == 4'd3 || op == 4'd5 || op == 4'd14) begin
                    dec.imm = {{(DATA_WIDTH-16){in_instr[15]}}, in_instr[15:0]};
                end else begin
                    dec.imm[15:0] = in_instr[15:0];
                end
            end
            4'd2: dec.imm = {{(DATA_WIDTH-16){in_instr[15]}}, in_instr[15:0]};
            4'd5: begin
                if (op >= 4'd8) begin
                    dec.imm = {{(DATA_WIDTH-12){in_instr[15]}}, in_instr[15:4]};
                end
            end
            default: dec.imm = '0;
        endcase

        if (grp == 4'd5) begin
            dec.ldst_type = op[2:0];
        end
        if (grp == 4'd2 || grp == 4'd3 || grp == 4'd4) begin
            dec.cond_type = op;
        end

        dec.causes_stall = (grp == 4'd3) || (grp == 4'd4) || (grp == 4'd5)
                         || ((grp == 4'd0 || grp == 4'd1) && op == 4'd6);

`ifdef INSTR_DECODE_ILLEGAL_EN
        dec.illegal = (grp > 4'd5)
                    || (grp == 4'd0 && op >= 4'd14)
                    || ((grp >= 4'd2 && grp <= 4'd4) && op >= 4'd10)
                    || ((grp == 4'd0 || grp == 4'd3 || grp == 4'd4)
                        && in_instr[15:4] != 12'd0);
        if (dec.illegal) begin
            dec.causes_stall = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            loaded <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                loaded <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset. The head mux reads zero until the first real
    // write after reset, so out_* are 0 out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= dec;
        end
    end

    assign head = loaded ? mem[rd_ptr] : '0;

    assign out_pc           = head.pc;
    assign out_group        = head.group;
    assign out_ra           = head.ra;
    assign out_rb           = head.rb;
    assign out_rc           = head.rc;
    assign out_opcode       = head.opcode;
    assign out_imm          = head.imm;
    assign out_ldst_type    = head.ldst_type;
    assign out_cond_type    = head.cond_type;
    assign out_causes_stall = head.causes_stall;
`ifdef INSTR_DECODE_ILLEGAL_EN
    assign out_illegal      = head.illegal;
`endif

endmodule

// File: tb/tb_instr_decode_queue.sv
// Scoreboard bench for instr_decode_queue (DEPTH=4, 32-bit widths).
// The driver issues directed words with hand-computed decodes.
// The monitor queues each expected entry when it is accepted, and pops and
// compares the entry when the DUT hands it to execute.
module tb_instr_decode_queue;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  grp, ra, rb, rc, op;
        logic [31:0] imm;
        logic [2:0]  ldst;
        logic [3:0]  cond;
        logic        stall;
        logic        ill;
    } exp_t;

`ifdef INSTR_DECODE_ILLEGAL_EN
    localparam logic ILL9 = 1'b1;
`else
    localparam logic ILL9 = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [3:0]  out_group, out_ra, out_rb, out_rc, out_opcode, out_cond_type;
    logic [2:0]  out_ldst_type;
    logic        out_causes_stall;
    logic [2:0]  count;
`ifdef INSTR_DECODE_ILLEGAL_EN
    logic        out_illegal;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t cur_exp;
    exp_t mon_e;
    exp_t ve[12];
    logic [31:0] vi[12];

    always #5 clk = ~clk;

    instr_decode_queue #(.DEPTH(4), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_group(out_group),
        .out_ra(out_ra), .out_rb(out_rb), .out_rc(out_rc),
        .out_opcode(out_opcode), .out_imm(out_imm),
        .out_ldst_type(out_ldst_type), .out_cond_type(out_cond_type),
        .out_causes_stall(out_causes_stall),
`ifdef INSTR_DECODE_ILLEGAL_EN
        .out_illegal(out_illegal),
`endif
        .count(count)
    );

    function automatic exp_t mk(input logic [31:0] pc, input logic [3:0] grp,
                                input logic [3:0] ra, input logic [3:0] rb,
                                input logic [3:0] rc, input logic [3:0] op,
                                input logic [31:0] imm, input logic [2:0] ldst,
                                input logic [3:0] cond, input logic stall,
                                input logic ill);
        exp_t e;
        e.pc = pc; e.grp = grp; e.ra = ra; e.rb = rb; e.rc = rc; e.op = op;
        e.imm = imm; e.ldst = ldst; e.cond = cond; e.stall = stall; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop-and-compare before queuing, so a same-cycle push lands behind.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pop: got pc %0h expected no entry", out_pc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("pc",     64'(out_pc),           64'(mon_e.pc));
                    chk("group",  64'(out_group),        64'(mon_e.grp));
                    chk("ra",     64'(out_ra),           64'(mon_e.ra));
                    chk("rb",     64'(out_rb),           64'(mon_e.rb));
                    chk("rc",     64'(out_rc),           64'(mon_e.rc));
                    chk("opcode", 64'(out_opcode),       64'(mon_e.op));
                    chk("imm",    64'(out_imm),          64'(mon_e.imm));
                    chk("ldst",   64'(out_ldst_type),    64'(mon_e.ldst));
                    chk("cond",   64'(out_cond_type),    64'(mon_e.cond));
                    chk("stall",  64'(out_causes_stall), 64'(mon_e.stall));
`ifdef INSTR_DECODE_ILLEGAL_EN
                    chk("illegal", 64'(out_illegal),     64'(mon_e.ill));
`endif
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    // Present a word and hold it until accepted; returns just after the accept edge.
    task automatic push_word(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
        bit acc = 0;
        in_instr = instr;
        in_pc    = pc;
        cur_exp  = e;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                break;
            end
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: pc %0h not accepted in 50 cycles", pc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (count == 0) break;
        end
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_sb", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vi[0]  = 32'h1120_FFFF; ve[0]  = mk(32'h100, 1, 1, 2, 0, 4'h0, 32'h0000_FFFF, 0, 0, 0, 0);
        vi[1]  = 32'h2120_FFFC; ve[1]  = mk(32'h104, 2, 1, 2, 0, 4'h0, 32'hFFFF_FFFC, 0, 0, 0, 0);
        vi[2]  = 32'h5123_FF88; ve[2]  = mk(32'h108, 5, 1, 2, 3, 4'h8, 32'hFFFF_FFF8, 0, 0, 1, 0);
        vi[3]  = 32'h0345_0006; ve[3]  = mk(32'h10C, 0, 3, 4, 5, 4'h6, 32'h0,         0, 0, 1, 0);
        vi[4]  = 32'h1236_1234; ve[4]  = mk(32'h110, 1, 2, 3, 0, 4'h6, 32'h0000_1234, 0, 0, 1, 0);
        vi[5]  = 32'h123F_ABCD; ve[5]  = mk(32'h114, 1, 2, 3, 0, 4'hF, 32'hABCD_0000, 0, 0, 0, 0);
        vi[6]  = 32'h1233_8000; ve[6]  = mk(32'h118, 1, 2, 3, 0, 4'h3, 32'hFFFF_8000, 0, 0, 0, 0);
        vi[7]  = 32'h3456_0009; ve[7]  = mk(32'h11C, 3, 4, 5, 6, 4'h9, 32'h0,         0, 9, 1, 0);
        vi[8]  = 32'h5210_0003; ve[8]  = mk(32'h120, 5, 2, 1, 0, 4'h3, 32'h0,         3, 0, 1, 0);
        vi[9]  = 32'h5210_FFFD; ve[9]  = mk(32'h124, 5, 2, 1, 0, 4'hD, 32'hFFFF_FFFF, 5, 0, 1, 0);
        vi[10] = 32'h9876_5432; ve[10] = mk(32'h128, 9, 8, 7, 6, 4'h2, 32'h0,         0, 0, 0, ILL9);
        vi[11] = 32'h4ABC_0002; ve[11] = mk(32'h12C, 4, 4'hA, 4'hB, 4'hC, 4'h2, 32'h0, 0, 2, 1, 0);

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; cur_exp = ve[0];
        #12;
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc",    64'(out_pc),    64'd0);
        chk("rst_out_imm",   64'(out_imm),   64'd0);
        chk("rst_out_group", 64'(out_group), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single word: visible at the head one cycle after acceptance.
        out_ready = 1'b1;
        push_word(vi[0], 32'h100, ve[0]);
        @(negedge clk);
        chk("latency_out_valid", 64'(out_valid), 64'd1);
        chk("latency_count",     64'(count),     64'd1);
        @(posedge clk); #1;
        for (int k = 1; k < 12; k++) push_word(vi[k], ve[k].pc, ve[k]);
        drain();

        // Fill to DEPTH with execute stalled, then release across the wrap.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            push_word(32'h0123_0000 | 32'(i), 32'h200 + 32'(4*i),
                      mk(32'h200 + 32'(4*i), 0, 1, 2, 3, 4'(i), 0, 0, 0, 0, 0));
        in_instr = 32'h0123_0004; in_pc = 32'h210;
        cur_exp  = mk(32'h210, 0, 1, 2, 3, 4'h4, 0, 0, 0, 0, 0);
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("full_count",     64'(count),     64'd4);
        chk("full_in_ready",  64'(in_ready),  64'd0);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        push_word(32'h0123_0004, 32'h210, mk(32'h210, 0, 1, 2, 3, 4'h4, 0, 0, 0, 0, 0));
        drain();

        // Flush with a same-cycle push: the pushed word is dropped.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            push_word(32'h0123_0001, 32'h300 + 32'(4*i),
                      mk(32'h300 + 32'(4*i), 0, 1, 2, 3, 4'h1, 0, 0, 0, 0, 0));
        @(negedge clk);
        chk("pre_flush_count", 64'(count), 64'd3);
        @(posedge clk); #1;
        in_instr = 32'h0123_0002; in_pc = 32'h3FC;
        cur_exp  = mk(32'h3FC, 0, 1, 2, 3, 4'h2, 0, 0, 0, 0, 0);
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_count",     64'(count),     64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        push_word(32'h1120_0005, 32'h400, mk(32'h400, 1, 1, 2, 0, 4'h0, 32'h5, 0, 0, 0, 0));
        drain();

`ifdef INSTR_DECODE_ILLEGAL_EN
        push_word(32'h7000_0000, 32'h500, mk(32'h500, 7, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1));
        push_word(32'h0123_0010, 32'h504, mk(32'h504, 0, 1, 2, 3, 4'h0, 0, 0, 0, 0, 1));
        drain();
`endif

        // Asynchronous reset mid-push clears the queue and zeroes the outputs.
        out_ready = 1'b0;
        push_word(vi[2], 32'h600, mk(32'h600, 5, 1, 2, 3, 4'h8, 32'hFFFF_FFF8, 0, 0, 1, 0));
        push_word(vi[9], 32'h604, mk(32'h604, 5, 2, 1, 0, 4'hD, 32'hFFFF_FFFF, 5, 0, 1, 0));
        in_instr = vi[4]; in_pc = 32'h608; in_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count",     64'(count),            64'd0);
        chk("mid_rst_in_ready",  64'(in_ready),         64'd1);
        chk("mid_rst_out_valid", 64'(out_valid),        64'd0);
        chk("mid_rst_out_pc",    64'(out_pc),           64'd0);
        chk("mid_rst_out_imm",   64'(out_imm),          64'd0);
        chk("mid_rst_stall",     64'(out_causes_stall), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_count", 64'(count),     64'd0);
        chk("post_rst_sb",    64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_decode_queue.md
Name: instr_decode_queue

Overview:
- Registered, buffered successor to the Frost32 combinational instruction-decode types.
- Accepts 32-bit fetched instruction words plus PC over a valid/ready handshake and decodes groups 0–5 into a wide decoded bundle.
- Holds up to DEPTH decoded entries in a circular queue ahead of the execute stage.
- Sits between fetch and register-read/execute; decouples fetch stalls from execute stalls and supports pipeline flush.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- DATA_WIDTH, 32, width of the extended immediate output; >= 32.
- ADDR_WIDTH, 32, PC width carried alongside each instruction.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards all queued entries.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept; equals (count < DEPTH).
- in_instr  in  32  raw instruction word.
- in_pc  in  ADDR_WIDTH  PC of in_instr.
- out_valid  out  1  head entry valid; equals (count != 0).
- out_ready  in  1  execute consumes the head.
- out_pc  out  ADDR_WIDTH  PC of the head entry.
- out_group  out  4  instr[31:28].
- out_ra, out_rb, out_rc  out  4 each  register indices.
- out_opcode  out  4  per-group operation.
- out_imm  out  DATA_WIDTH  extended immediate.
- out_ldst_type  out  3  Ld32=0, LdU16, LdS16, LdU8, LdS8, St32, St16, St8=7.
- out_cond_type  out  4  CtNe=0 … CtGts=9; values 10–15 are bad.
- out_causes_stall  out  1  multi-cycle instruction flag.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Field layout, fixed:
  - group [31:28], ra [27:24], rb [23:20].
  - Groups 0, 3, 4: rc [19:16], fill [15:4], opcode [3:0].
  - Groups 1, 2: opcode [19:16], imm16 [15:0]; rc output is 0.
  - Group 5: rc [19:16], imm12 [15:4], opcode [3:0].
- Immediate:
  - Group 0, 3, 4: imm = 0.
  - Group 1 opcodes 3, 5, 14: sign-extend imm16.
  - Group 1 opcode 15 (cpyhi): imm16 << 16, zero above bit 31.
  - Group 1, other opcodes: zero-extend imm16.
  - Group 2: sign-extend imm16.
  - Group 5, opcode >= 8: sign-extend imm12.
  - Group 5, opcode < 8: imm = 0.
- ldst_type = opcode[2:0] for group 5; 0 otherwise.
- cond_type = opcode for groups 2, 3, 4; 0 otherwise.
- causes_stall = 1 for:
  - group 5;
  - groups 3 and 4;
  - group 0 opcode 6 (mul);
  - group 1 opcode 6 (muli).
- Groups 6–15 decode as fields only: imm = 0, causes_stall = 0.
- Decode is combinational on the input side and is written into the queue on accept (in_valid & in_ready).
- Latency: word accepted in cycle N appears at the head in cycle N+1 when the queue was empty. There is no bypass.
- Pop on out_valid & out_ready.
- Simultaneous push and pop:
  - Allowed when full: in_ready stays 0 that cycle (registered-count based), so push is blocked.
  - When partially full: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; count saturates logic never exceeds DEPTH.
- Empty: out_valid = 0; out_* hold the last head-slot contents; the consumer must ignore them.
- flush: next cycle count = 0, pointers = 0, out_valid = 0. Flush wins over a same-cycle push or pop; the pushed word is dropped.
- Reset (any time, including mid-push): count = 0, pointers = 0, in_ready = 1, out_valid = 0, all out_* fields = 0.
- Storage contents need no reset beyond the output mux reading 0.

Optional Feature:
- Macro: INSTR_DECODE_ILLEGAL_EN.
- When defined, adds output out_illegal (1 bit), stored per entry. It is set for:
  - group > 5;
  - group 0 opcode 14/15;
  - groups 2–4 opcode >= 10;
  - group 0, 3, 4 fill != 0.
- When defined, illegal entries force causes_stall = 0.
- When undefined, the port is absent and no illegal checking exists.

Test Plan:
- Reset then push 0x1120_FFFF (addi r2, r0… imm 0xFFFF) at PC 0x100 -> next cycle out_valid = 1, group = 1, opcode = 0, imm = 0x0000_FFFF, pc = 0x100.
- Push 0x2120_FFFC (branch opcode 0, CtNe) -> imm = 0xFFFF_FFFC, cond_type = 0, causes_stall = 0.
- Push 0x5123_FF88 (group 5 opcode 8, imm12 0xFF8) -> imm = 0xFFFF_FFF8, ldst_type = 0, causes_stall = 1.
- With out_ready = 0, push DEPTH+1 words -> in_ready drops after DEPTH accepts, count = DEPTH. Then set out_ready = 1 -> PCs pop in order across the pointer wrap.
- Fill to 3 entries, assert flush together with in_valid -> next cycle count = 0, out_valid = 0, the pushed word never appears.
- With INSTR_DECODE_ILLEGAL_EN defined, push 0x7000_0000 -> out_illegal = 1, causes_stall = 0. Push 0x0123_0010 (fill != 0) -> out_illegal = 1.
